// File: rtl/rr_mux_sched.sv
// Round-robin scheduler sharing a 4:1 single-bit mux between four requesters.
// Grants are held until done, withdrawal or MAX_HOLD timeout, followed by a one-cycle GAP.
module rr_mux_sched #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    input  logic [3:0] a,
    output logic [3:0] grant,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       c,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? {CNT_W{1'b0}} : CNT_W'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [1:0]       sel, sel_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       grant_n;
    logic             busy_n;
    logic             timeout_n;
    logic [1:0]       winner;
    logic             hold_expired;
    logic             release_now;

    // First set request bit scanning upward from p, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] w;
        logic       found;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = rr_pick(req, ptr);

    // While in GRANT the select register doubles as the holder index.
    assign hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign release_now  = done || !req[sel] || hold_expired;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel;
        cnt_n     = cnt;
        grant_n   = grant;
        busy_n    = busy;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_n = GRANT;
                    grant_n = 4'b0001 << winner;
                    sel_n   = winner;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_n   = GAP;
                    grant_n   = 4'b0000;
                    busy_n    = 1'b0;
                    ptr_n     = sel + 2'd1;
                    cnt_n     = '0;
                    // Only a counter-only release is reported as a timeout.
                    timeout_n = !done && req[sel];
                end else if (MAX_HOLD != 0) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            sel     <= 2'd0;
            cnt     <= '0;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            sel     <= sel_n;
            cnt     <= cnt_n;
            grant   <= grant_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

    assign s0 = sel[1];
    assign s1 = sel[0];
    assign c  = busy ? a[sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Bench for rr_mux_sched (MAX_HOLD=4): vector table fed through an expectation queue,
// plus hand-written reset sequences.
module tb_rr_mux_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] a;
    logic [3:0] grant;
    logic       s0, s1, busy, c, timeout;

    int checks = 0;
    int errors = 0;

    rr_mux_sched #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .a(a),
        .grant(grant), .s0(s0), .s1(s1), .busy(busy), .c(c), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] a;
        logic [3:0] g;
        logic [1:0] sel;
        logic       busy;
        logic       to;
        logic       c;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    task automatic cmp(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input vec_t e);
        cmp("grant",   idx, grant, e.g);
        cmp("s0s1",    idx, {2'b00, s0, s1}, {2'b00, e.sel});
        cmp("busy",    idx, {3'b000, busy}, {3'b000, e.busy});
        cmp("timeout", idx, {3'b000, timeout}, {3'b000, e.to});
        cmp("c",       idx, {3'b000, c}, {3'b000, e.c});
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic d, input logic [3:0] av,
                                input logic [3:0] g, input logic [1:0] sl, input logic b,
                                input logic t, input logic cv);
        vec_t v;
        v.req = r; v.done = d; v.a = av; v.g = g; v.sel = sl; v.busy = b; v.to = t; v.c = cv;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        // inputs before the edge                 expected after the edge
        //          req     done a        grant    sel   busy to c
        tbl.push_back(mk(4'b1111, 0, 4'b0000, 4'b0001, 2'd0, 1, 0, 0)); // 0: grant 0
        tbl.push_back(mk(4'b1111, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0)); // 1: done -> GAP
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0)); // 2: IDLE
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0)); // 3: IDLE
        tbl.push_back(mk(4'b0101, 0, 4'b0100, 4'b0100, 2'd2, 1, 0, 1)); // 4: ptr=1 -> grant 2, c=1
        tbl.push_back(mk(4'b0101, 0, 4'b0000, 4'b0100, 2'd2, 1, 0, 0)); // 5: c=0
        tbl.push_back(mk(4'b0101, 0, 4'b0100, 4'b0100, 2'd2, 1, 0, 1)); // 6
        tbl.push_back(mk(4'b0101, 1, 4'b0100, 4'b0000, 2'd2, 0, 0, 0)); // 7: done -> GAP
        tbl.push_back(mk(4'b0101, 1, 4'b1111, 4'b0000, 2'd2, 0, 0, 0)); // 8: IDLE, done ignored, c=0
        tbl.push_back(mk(4'b0101, 0, 4'b1111, 4'b0001, 2'd0, 1, 0, 1)); // 9: ptr=3 wraps -> grant 0
        tbl.push_back(mk(4'b0101, 0, 4'b0000, 4'b0001, 2'd0, 1, 0, 0)); // 10
        tbl.push_back(mk(4'b0101, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0)); // 11: GAP
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0)); // 12: IDLE
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0010, 2'd1, 1, 0, 0)); // 13: grant 1, hold cycle 1
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0010, 2'd1, 1, 0, 0)); // 14: cycle 2
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0010, 2'd1, 1, 0, 0)); // 15: cycle 3
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0010, 2'd1, 1, 0, 0)); // 16: cycle 4
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0000, 2'd1, 0, 1, 0)); // 17: timeout in GAP
        tbl.push_back(mk(4'b0010, 0, 4'b0000, 4'b0000, 2'd1, 0, 0, 0)); // 18: IDLE
        tbl.push_back(mk(4'b0010, 0, 4'b0010, 4'b0010, 2'd1, 1, 0, 1)); // 19: regrant 1
        tbl.push_back(mk(4'b0010, 0, 4'b0010, 4'b0010, 2'd1, 1, 0, 1)); // 20
        tbl.push_back(mk(4'b0010, 0, 4'b0010, 4'b0010, 2'd1, 1, 0, 1)); // 21
        tbl.push_back(mk(4'b0010, 0, 4'b0010, 4'b0010, 2'd1, 1, 0, 1)); // 22: last hold cycle
        tbl.push_back(mk(4'b0010, 1, 4'b0010, 4'b0000, 2'd1, 0, 0, 0)); // 23: done+expiry, no pulse
        tbl.push_back(mk(4'b0000, 0, 4'b0000, 4'b0000, 2'd1, 0, 0, 0)); // 24: IDLE
        tbl.push_back(mk(4'b1000, 0, 4'b1000, 4'b1000, 2'd3, 1, 0, 1)); // 25: ptr=2 -> grant 3
        tbl.push_back(mk(4'b1001, 0, 4'b1000, 4'b1000, 2'd3, 1, 0, 1)); // 26: no preemption
        tbl.push_back(mk(4'b0001, 0, 4'b1000, 4'b0000, 2'd3, 0, 0, 0)); // 27: withdrawal -> GAP
        tbl.push_back(mk(4'b0001, 0, 4'b1000, 4'b0000, 2'd3, 0, 0, 0)); // 28: IDLE
        tbl.push_back(mk(4'b0001, 0, 4'b0001, 4'b0001, 2'd0, 1, 0, 1)); // 29: grant 0
        tbl.push_back(mk(4'b0001, 0, 4'b0001, 4'b0001, 2'd0, 1, 0, 1)); // 30: holding

        rst = 1'b1; req = 4'b1111; done = 1'b0; a = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1, mk(4'b1111, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 0));
        rst = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            a    = tbl[i].a;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard step %0d queue empty", i);
            end else begin
                e = exp_q.pop_front();
                check_outputs(i, e);
            end
        end

        // Asynchronous reset in the middle of a grant, away from any edge.
        #2;
        a   = 4'b1111;
        rst = 1'b1;
        #1;
        check_outputs(100, mk(4'b0001, 0, 4'b1111, 4'b0000, 2'd0, 0, 0, 0));
        @(posedge clk);
        #1;
        req = 4'b1111;
        a   = 4'b0000;
        rst = 1'b0;
        exp_q.push_back(mk(4'b1111, 0, 4'b0000, 4'b0001, 2'd0, 1, 0, 0));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(101, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_sched.md
Name: rr_mux_sched

Overview:
- Round-robin scheduler that shares a 4:1 single-bit mux between four requesters.
- Arbitrates req[3:0] and drives the mux select pair s0/s1 using the standard encoding:
  - s0s1 = 00 selects a[0]
  - 01 selects a[1]
  - 10 selects a[2]
  - 11 selects a[3]
- Holds each grant until the holder finishes, withdraws, or times out.
- Contains the mux internally; output c carries the granted requester's bit.

Parameters:
- MAX_HOLD, 8: maximum consecutive GRANT cycles per grant. 0 disables the timeout. Legal range 0..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  4  request lines, req[i] = requester i
- done  input  1  single-cycle pulse from the current holder marking end of use
- a  input  4  data bits, a[i] from requester i
- grant  output  4  one-hot registered grant, all-zero when no grant
- s0  output  1  registered mux select MSB
- s1  output  1  registered mux select LSB
- busy  output  1  high while in GRANT
- c  output  1  muxed data bit
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, ptr=0, cnt=0
  - grant=0000, s0=0, s1=0, busy=0, timeout=0
  - c=0 (combinational from busy)
- Reset asserted mid-grant drops grant and busy immediately, asynchronously.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise pick the winner w: the first set req bit searching ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - Next edge: state=GRANT, grant=onehot(w), {s0,s1}=w, busy=1, cnt=0.
  - Latency from req seen in IDLE to grant visible is 1 cycle.
- GRANT, with holder h:
  - Release condition is any of:
    - done=1
    - req[h]=0
    - MAX_HOLD!=0 and cnt==MAX_HOLD-1
  - On release, next edge: state=GAP, grant=0000, busy=0, ptr=h+1 mod 4.
  - Otherwise cnt increments by 1 and the grant holds.
- timeout:
  - Pulses 1 in the GAP cycle only when the release was caused solely by the counter, i.e. done=0 and req[h]=1.
  - done and timeout coinciding counts as a normal release: no pulse.
- Holder occupancy: the holder keeps grant for at most MAX_HOLD cycles, exactly MAX_HOLD if it never releases.
- GAP:
  - Always lasts one cycle, grant=0000.
  - Next edge goes to IDLE.
  - Minimum dead time between consecutive grants is 2 cycles (GAP plus IDLE).
- s0/s1:
  - Updated only on entering GRANT.
  - Hold the last granted index through GAP and IDLE.
- c:
  - c = busy ? a[{s0,s1}] : 0.
  - Purely combinational from the registered selects and a; no extra latency.
- Ignored inputs:
  - done is ignored outside GRANT.
  - Requests from non-holders during GRANT are ignored and do not preempt.
- Fairness: after releasing h, the next search starts at h+1, so any continuously asserted request is granted within 3 subsequent grants.
- MAX_HOLD=0: cnt does not need to count; release only by done or withdrawal.
- req bits are sampled synchronously and may change every cycle; no glitch filtering.

Test Plan:
- Reset with req=1111 held: after rst release, grant=0001 one cycle later, {s0,s1}=00, busy=1.
- req=0101, done pulsed 3 cycles after each grant: grants go 0001, GAP, IDLE, 0100, GAP, IDLE, 0001; ptr wraps correctly.
- Data path: grant on requester 2, a=0100 then 0000 -> c=1 then 0. When idle, c=0 with a=1111.
- MAX_HOLD=4, req=0010 held, no done: grant=0010 for exactly 4 cycles, then timeout=1 in the GAP cycle, then regrant to 0010.
- Simultaneous done and cnt==MAX_HOLD-1: release occurs and timeout stays 0.
- Withdrawal: holder 3 drops req[3] mid-grant while req=0001 -> GAP, then grant=0001 with ptr wrapped to 0. Asserting rst mid-grant -> grant=0000 and busy=0 without waiting for a clock edge.
